// File: rtl/pipeline_ctrl_if.sv
// Handshake/control bundle between the dtcore32 datapath and its hazard controller.
// Inputs to the controller are valid for the whole cycle; outputs are combinational same-cycle.
interface pipeline_ctrl_if #(
  parameter int STALL_CNT_W = 32
);
  logic [4:0]             id_rs1_addr;
  logic [4:0]             id_rs2_addr;
  logic                   id_rs1_used;
  logic                   id_rs2_used;
  logic                   ex_valid;
  logic                   ex_is_load;
  logic [4:0]             ex_rd_addr;
  logic                   ex_redirect;
  logic                   mem_trap;
  logic                   dmem_req;
  logic                   dmem_rvalid;
  logic                   imem_req;
  logic                   imem_rvalid;
  logic                   imem_req_allow;
  logic                   imem_discard;
  logic                   if_stall;
  logic                   if_id_stall;
  logic                   id_ex_stall;
  logic                   ex_mem_stall;
  logic                   mem_wb_stall;
  logic                   if_id_flush;
  logic                   id_ex_flush;
  logic                   ex_mem_flush;
  logic                   mem_wb_flush;
  logic                   if_id_bubble;
  logic                   id_ex_bubble;
  logic                   mem_wb_bubble;
  logic [STALL_CNT_W-1:0] stall_cycles;
  logic                   dm_state_dbg;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, ex_valid, ex_is_load,
           ex_rd_addr, ex_redirect, mem_trap, dmem_req, dmem_rvalid, imem_req, imem_rvalid,
    input  imem_req_allow, imem_discard, if_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           mem_wb_stall, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           if_id_bubble, id_ex_bubble, mem_wb_bubble, stall_cycles, dm_state_dbg
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, ex_valid, ex_is_load,
           ex_rd_addr, ex_redirect, mem_trap, dmem_req, dmem_rvalid, imem_req, imem_rvalid,
    output imem_req_allow, imem_discard, if_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           mem_wb_stall, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           if_id_bubble, id_ex_bubble, mem_wb_bubble, stall_cycles, dm_state_dbg
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/stall/flush controller for the 5-stage dtcore32 pipeline: dmem wait tracking,
// load-use detection, EX redirects, MEM traps and stale-fetch discarding.
module pipeline_ctrl #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STALL_CNT_W     = 32
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);
  typedef enum logic {DM_IDLE, DM_WAIT} dm_state_t;

  dm_state_t              dm_state, dm_state_next;
  logic [2:0]             outstanding_cnt, outstanding_next;
  logic [2:0]             discard_cnt, discard_next;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   dmem_stall, trap_act, redirect_act, load_use, load_use_act;
  logic                   mark_stale, if_stall_int, discard_int;

  always_ff @(posedge clk) begin
    if (rst) dm_state <= DM_IDLE;
    else     dm_state <= dm_state_next;
  end

  // A response arriving in DM_IDLE is ignored: it neither changes state nor releases anything.
  always_comb begin
    dm_state_next = dm_state;
    dmem_stall    = 1'b0;
    case (dm_state)
      DM_IDLE: begin
        dmem_stall = bus.dmem_req;
        if (bus.dmem_req) dm_state_next = DM_WAIT;
      end
      DM_WAIT: begin
        dmem_stall = !bus.dmem_rvalid;
        if (bus.dmem_rvalid) dm_state_next = DM_IDLE;
      end
      default: dm_state_next = DM_IDLE;
    endcase
  end

  always_comb begin
    load_use = bus.ex_valid && bus.ex_is_load && (bus.ex_rd_addr != 5'd0) &&
               ((bus.id_rs1_used && (bus.id_rs1_addr == bus.ex_rd_addr)) ||
                (bus.id_rs2_used && (bus.id_rs2_addr == bus.ex_rd_addr)));
    // A trap only counts when the MEM stage is not mid-access; otherwise it is held in EX/MEM.
    trap_act     = !rst && bus.mem_trap && (dm_state == DM_IDLE) && !bus.dmem_req;
    redirect_act = !rst && !trap_act && !dmem_stall && bus.ex_redirect && bus.ex_valid;
    load_use_act = !rst && !trap_act && !dmem_stall && !redirect_act && load_use;
    mark_stale   = trap_act || redirect_act;
    if_stall_int = !rst && (dmem_stall || load_use_act);
    discard_int  = !rst && bus.imem_rvalid && ((discard_cnt != 3'd0) || mark_stale);
  end

  always_comb begin
    bus.imem_req_allow = !rst && ((outstanding_cnt < 3'(MAX_OUTSTANDING)) || bus.imem_rvalid);
    bus.imem_discard   = discard_int;
    bus.if_stall       = if_stall_int;
    bus.if_id_stall    = if_stall_int;
    bus.id_ex_stall    = !rst && dmem_stall;
    bus.ex_mem_stall   = !rst && dmem_stall;
    bus.mem_wb_stall   = 1'b0;
    bus.if_id_flush    = rst || mark_stale;
    bus.id_ex_flush    = rst || mark_stale;
    bus.ex_mem_flush   = rst || trap_act;
    bus.mem_wb_flush   = rst;
    // Fetch bubble only applies when IF/ID is actually loading this cycle.
    bus.if_id_bubble   = !rst && !if_stall_int && !mark_stale && (!bus.imem_rvalid || discard_int);
    bus.id_ex_bubble   = load_use_act;
    bus.mem_wb_bubble  = !rst && (trap_act || dmem_stall);
    bus.stall_cycles   = stall_cnt;
    bus.dm_state_dbg   = (dm_state == DM_WAIT);
  end

  always_comb begin
    outstanding_next = outstanding_cnt + {2'b00, bus.imem_req} - {2'b00, bus.imem_rvalid};
    discard_next     = discard_cnt;
    if (mark_stale)                                   discard_next = outstanding_next;
    else if (bus.imem_rvalid && discard_cnt != 3'd0)  discard_next = discard_cnt - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_cnt <= 3'd0;
      discard_cnt     <= 3'd0;
      stall_cnt       <= '0;
    end else begin
      outstanding_cnt <= outstanding_next;
      discard_cnt     <= discard_next;
      if (if_stall_int && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  a_req_allowed: assert property (@(posedge clk) disable iff (rst)
    bus.imem_req |-> bus.imem_req_allow);
endmodule
